// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux bus arbiter.
//   arb_state_t : arbiter FSM state (IDLE dead/arbitration cycle, GRANT bus owned)
//   next_rr     : round-robin pointer advance with wrap n-1 -> 0
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Advance a round-robin pointer by one, wrapping at n.
  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
    return ((ptr + 32'd1) >= n) ? 32'd0 : (ptr + 32'd1);
  endfunction

endpackage

// File: rtl/mux_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping NUM_REQ-1 -> 0.
//   req     : request vector
//   rr_ptr  : highest-priority index this round
//   idx     : index of the winner (0 when no request)
//   onehot  : one-hot of the winner (all zero when no request)
//   any_req : at least one request is set
module rr_pick #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SEL_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SEL_WIDTH-1:0] rr_ptr,
  output logic [SEL_WIDTH-1:0] idx,
  output logic [NUM_REQ-1:0]   onehot,
  output logic                 any_req
);

  logic [NUM_REQ-1:0] rot;
  int unsigned        src;
  int unsigned        first;
  int unsigned        sum;

  // Rotate so rr_ptr lands on bit 0, find the lowest set bit, rotate the index back.
  always_comb begin
    rot   = '0;
    src   = 0;
    first = 0;
    sum   = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      src = 32'(i) + 32'(rr_ptr);
      if (src >= NUM_REQ) src = src - NUM_REQ;
      rot[i] = req[SEL_WIDTH'(src)];
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) first = 32'(i);
    end
    sum = first + 32'(rr_ptr);
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    any_req = |req;
    idx     = any_req ? SEL_WIDTH'(sum) : '0;
    onehot  = any_req ? (NUM_REQ'(1) << sum) : '0;
  end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter driving the select of a shared multiplexed datapath.
// One dead cycle separates consecutive owners; MAX_HOLD bounds a single grant.
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   req        : per-requester request, held while the bus is wanted
//   grant      : one-hot grant or zero
//   mux_select : owner index for the multiplexer control
//   bus_valid  : multiplexer output carries the owner's data
module mux_bus_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SEL_WIDTH = $clog2(NUM_REQ),
  parameter int unsigned MAX_HOLD  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_WIDTH-1:0] mux_select,
  output logic                 bus_valid
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [SEL_WIDTH-1:0] sel_d;
  logic                 valid_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic [SEL_WIDTH-1:0] pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 pick_any;
  logic                 owner_req;
  logic                 timeout;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_pick (
    .req    (req),
    .rr_ptr (ptr_q),
    .idx    (pick_idx),
    .onehot (pick_onehot),
    .any_req(pick_any)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant      <= '0;
      mux_select <= '0;
      bus_valid  <= 1'b0;
      ptr_q      <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant      <= grant_d;
      mux_select <= sel_d;
      bus_valid  <= valid_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state: arbitrate in IDLE, release or preempt in GRANT.
  // mux_select is left untouched on release so the select never glitches.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    sel_d     = mux_select;
    valid_d   = bus_valid;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    owner_req = |(req & grant);
    timeout   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick_onehot;
          sel_d   = pick_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!owner_req || timeout) begin
          state_d = IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = SEL_WIDTH'(next_rr(32'(mux_select), NUM_REQ));
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Self-checking bench for mux_bus_arbiter (NUM_REQ=4, MAX_HOLD=8).
// Each step drives req/reset, pushes the reference model's expected outputs,
// then pops and compares them one edge later.
module tb_mux_bus_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int MH = 8;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [SW-1:0] mux_select;
  logic          bus_valid;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          valid;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int           m_state;
  int           m_sel;
  int           m_ptr;
  int           m_hold;
  logic [N-1:0] m_grant;

  // Last observed DUT outputs
  logic [N-1:0]  gr;
  logic [SW-1:0] sl;
  logic          bv;

  mux_bus_arbiter #(
    .NUM_REQ (N),
    .MAX_HOLD(MH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .mux_select(mux_select),
    .bus_valid (bus_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic rst);
    int pick;
    int idx;
    if (rst) begin
      m_state = 0; m_grant = '0; m_sel = 0; m_ptr = 0; m_hold = 0;
    end else if (m_state == 0) begin
      pick = -1;
      for (int k = N - 1; k >= 0; k--) begin
        idx = (m_ptr + k) % N;
        if (r[idx]) pick = idx;
      end
      if (pick >= 0) begin
        m_state = 1; m_grant = '0; m_grant[pick] = 1'b1; m_sel = pick; m_hold = 0;
      end
    end else if (!r[m_sel] || m_hold == MH - 1) begin
      m_state = 0; m_grant = '0; m_ptr = (m_sel + 1) % N;
    end else if (m_hold < MH - 1) begin
      m_hold = m_hold + 1;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rst);
    exp_t e;
    @(negedge clk);
    req   = r;
    reset = rst;
    model_step(r, rst);
    e.grant = m_grant;
    e.sel   = SW'(m_sel);
    e.valid = (m_state != 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    gr = grant; sl = mux_select; bv = bus_valid;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("grant", 32'(gr), 32'(e.grant));
      chk("sel",   32'(sl), 32'(e.sel));
      chk("valid", 32'(bv), 32'(e.valid));
    end
    chk("onehot0",  32'($onehot0(gr)), 32'd1);
    chk("valid_eq", 32'(bv), 32'(gr != '0));
    if (bv) chk("sel_owner", 32'(gr[sl]), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;

    // Idle bus
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("rst_grant", 32'(gr), 32'd0);
    chk("rst_sel",   32'(sl), 32'd0);
    chk("rst_valid", 32'(bv), 32'd0);
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);
    chk("idle_grant", 32'(gr), 32'd0);

    // Basic grant with dead cycle
    step(4'b0101, 1'b0);
    chk("basic_g1", 32'(gr), 32'h1);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    chk("basic_g3", 32'(gr), 32'h1);
    step(4'b0100, 1'b0);
    chk("basic_dead", 32'(gr), 32'h0);
    chk("basic_dead_sel", 32'(sl), 32'd0);
    step(4'b0100, 1'b0);
    chk("basic_g5", 32'(gr), 32'h4);
    chk("basic_s5", 32'(sl), 32'd2);

    // Pointer wrap: requester 2 releases, rr_ptr now 3
    step(4'b0000, 1'b0);
    step(4'b1001, 1'b0);
    chk("wrap_g3", 32'(gr), 32'h8);
    chk("wrap_s3", 32'(sl), 32'd3);
    step(4'b0001, 1'b0);
    chk("wrap_dead_sel", 32'(sl), 32'd3);
    chk("wrap_dead_v", 32'(bv), 32'd0);
    step(4'b0001, 1'b0);
    chk("wrap_g0", 32'(gr), 32'h1);
    chk("wrap_s0", 32'(sl), 32'd0);
    step(4'b0000, 1'b0);

    // Round-robin fairness: order 0,1,2,3,0
    step(4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] oh;
      oh = 4'b0001 << (k % N);
      step(4'b1111, 1'b0);
      chk("rr_grant", 32'(gr), 32'(oh));
      step(4'b1111, 1'b0);
      step(4'b1111 & ~oh, 1'b0);
      chk("rr_dead", 32'(gr), 32'h0);
    end

    // Timeout: sole requester holds req for 20 cycles
    step(4'b0000, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      step(4'b0001, 1'b0);
      chk("timeout_g0", 32'(gr[0]), (c == 9 || c == 18) ? 32'd0 : 32'd1);
    end

    // Reset mid-grant
    step(4'b0000, 1'b1);
    for (int c = 0; c < 5; c++) step(4'b0010, 1'b0);
    chk("mid_pre", 32'(gr), 32'h2);
    step(4'b0010, 1'b1);
    chk("mid_rst_g", 32'(gr), 32'h0);
    chk("mid_rst_s", 32'(sl), 32'd0);
    chk("mid_rst_v", 32'(bv), 32'd0);
    step(4'b1111, 1'b0);
    chk("mid_after", 32'(gr), 32'h1);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
